ctrl_fsm: RTL
=============

Name: ctrl_fsm

Overview:
- Multi-cycle fetch/decode/execute controller sitting directly downstream of the instruction memory.
- Owns the program counter and drives the memory read address. Consumes the 5-bit instruction word one cycle later and issues one-cycle control strobes to the register file and ALU datapath.
- Handles one-word and two-word (immediate/target) instructions, conditional jump on the datapath zero flag, and halt.

Parameters:
- PC_W, 4, program counter / memory address width (16-word memory)
- INS_W, 5, instruction word width delivered by memory
- RA_W, 2, register index width (4 registers)
- DATA_W, 16, datapath width for immediate output

Ports:
- clk  in  1  system clock, all state on rising edge
- start  in  1  synchronous active-high reset; same signal that loads the program image into memory
- ins  in  INS_W  instruction word from memory, valid the cycle after r_addr is presented
- zero  in  1  datapath zero flag, sampled only in EXEC
- r_addr  out  PC_W  memory read address, equal to the registered pc
- w_addr  out  PC_W  memory write address, held at 4'hF (scratch word; memory writes every cycle)
- rf_we  out  1  register-file write strobe, one cycle
- rf_waddr  out  RA_W  register written
- rf_raddr  out  RA_W  register read onto ALU operand
- alu_op  out  2  00 PASS_IMM, 01 ADD, 10 SUB, 11 PASS_REG
- imm  out  DATA_W  zero-extended operand word
- halted  out  1  high once HALT executed

Behaviour:
- Reset (start=1 at a clk edge, any state):
  - state=FETCH, pc=0, ir=0, opnd=0.
  - All outputs 0 except w_addr=4'hF.
  - Reset mid-instruction abandons it; no strobe is issued.
- Encoding: op=ins[4:2], rd=ins[1:0].
  - 000 NOP
  - 001 LDI rd (2-word)
  - 010 ADD rd (rd<=rd+r0)
  - 011 SUB rd (rd<=rd-r0)
  - 100 MOV rd (r0<=rd)
  - 101 JMP (2-word)
  - 110 JZ (2-word)
  - 111 HALT
- States and transitions:
  - FETCH: r_addr=pc; pc<=pc+1; go to DECODE.
  - DECODE: latch ir<=ins. If 2-word op, pc<=pc+1 and go to OPND; else go to EXEC.
  - OPND: latch opnd<=ins; go to EXEC.
  - EXEC: drive strobes for exactly one cycle, then FETCH. HALT instead goes to HALTED.
- Latency: 1-word op = 3 cycles (FETCH, DECODE, EXEC); 2-word op = 4 cycles.
- EXEC outputs:
  - LDI: rf_we=1, rf_waddr=rd, alu_op=PASS_IMM, imm={11'b0,opnd}.
  - ADD/SUB: rf_we=1, rf_waddr=rd, rf_raddr=rd, alu_op=ADD/SUB.
  - MOV: rf_we=1, rf_waddr=0, rf_raddr=rd, alu_op=PASS_REG.
  - JMP: pc<=opnd[PC_W-1:0].
  - JZ: pc<=opnd[3:0] if zero=1, else pc unchanged (already past operand).
  - NOP: no strobe.
- Outside EXEC: rf_we=0. Other control outputs hold their last value.
- pc wraps 15->0 modulo 2^PC_W. A 2-word op at address 15 takes its operand from address 0.
- HALTED: pc and outputs frozen, halted=1, all strobes 0. Only start exits.
- ins arriving while the FSM is in FETCH or EXEC is ignored.

Optional Feature:
- Macro CTRL_STEP_EN.
- Defined: adds input step (1 bit). FETCH advances only when step=1 that cycle; otherwise the FSM holds FETCH with pc unchanged. Exactly one instruction runs per step pulse, and step held high runs freely.
- Undefined: no step port; FETCH always advances.

Decomposition:
- Package simple_cpu_pkg holds:
  - opcode constants OP_NOP..OP_HALT
  - state enum FETCH/DECODE/OPND/EXEC/HALTED
  - alu_op codes
  - SCRATCH_ADDR=4'hF
- One natural sub-module: pc_reg, the PC counter with sync clear, increment and load, wrapping.

Test Plan:
- Program {5,3,9,28}, start pulse:
  - LDI r1 gives rf_we=1, rf_waddr=1, imm=3, alu_op=00 at cycle 4.
  - ADD r1 gives rf_we=1, rf_waddr=1, rf_raddr=1, alu_op=01 at cycle 7.
  - halted=1 from cycle 10.
- Program {20,6} (JMP 6) then NOP at 6: r_addr=6 in the FETCH following EXEC; no rf_we pulse.
- JZ {24,9}: with zero=1 in EXEC, next r_addr=9; with zero=0, next r_addr=2.
- 2-word LDI placed at address 15: operand fetched from address 0; following FETCH has r_addr=1.
- Assert start during OPND of an LDI: next cycle state=FETCH, r_addr=0, rf_we never pulses.
- With CTRL_STEP_EN and step=0: r_addr stays 0 indefinitely; one step pulse executes exactly one instruction.

Source files
------------

// File: rtl/simple_cpu_pkg.sv
// simple_cpu_pkg: shared opcodes, FSM state encoding, ALU op codes and
// fixed addresses for the fetch/decode/execute controller.
package simple_cpu_pkg;

   // Instruction opcodes, carried in ins[4:2].
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LDI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MOV  = 3'b100;
   localparam logic [2:0] OP_JMP  = 3'b101;
   localparam logic [2:0] OP_JZ   = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   // ALU operation select driven towards the datapath.
   localparam logic [1:0] ALU_PASS_IMM = 2'b00;
   localparam logic [1:0] ALU_ADD      = 2'b01;
   localparam logic [1:0] ALU_SUB      = 2'b10;
   localparam logic [1:0] ALU_PASS_REG = 2'b11;

   // Memory word that absorbs the unconditional per-cycle write.
   localparam logic [3:0] SCRATCH_ADDR = 4'hF;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      OPND,
      EXEC,
      HALTED
   } state_t;

   // Instructions that carry an operand word right after the opcode word.
   function automatic logic is_two_word(input logic [2:0] op);
      return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ);
   endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with synchronous clear, load and wrapping increment.
module pc_reg #(
   parameter int PC_W = 4
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            inc,
   input  logic            ld,
   input  logic [PC_W-1:0] ld_val,
   output logic [PC_W-1:0] pc
);

   // Clear beats load, load beats increment; the increment wraps modulo 2^PC_W.
   // NOTE: clocked state uses <= so every flop samples pre-edge values; = here would race readers.
   always_ff @(posedge clk) begin
      if (clr)
         pc <= '0;
      else if (ld)
         pc <= ld_val;
      else if (inc)
         pc <= pc + PC_W'(1);
   end

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle fetch/decode/execute controller in front of the
// instruction memory. Build with CTRL_STEP_EN defined to add a single-step
// input that gates each FETCH.
module ctrl_fsm
   import simple_cpu_pkg::*;
#(
   parameter int PC_W   = 4,
   parameter int INS_W  = 5,
   parameter int RA_W   = 2,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              start,
`ifdef CTRL_STEP_EN
   input  logic              step,
`endif
   input  logic [INS_W-1:0]  ins,
   input  logic              zero,
   output logic [PC_W-1:0]   r_addr,
   output logic [PC_W-1:0]   w_addr,
   output logic              rf_we,
   output logic [RA_W-1:0]   rf_waddr,
   output logic [RA_W-1:0]   rf_raddr,
   output logic [1:0]        alu_op,
   output logic [DATA_W-1:0] imm,
   output logic              halted
);

   state_t            state, state_d;
   logic [INS_W-1:0]  ir, opnd;
   logic [PC_W-1:0]   pc;
   logic [2:0]        op;
   logic [RA_W-1:0]   rd;
   logic              go;
   logic              pc_inc, pc_ld, ir_en, opnd_en;
   logic              we_d, halt_d;
   logic [RA_W-1:0]   waddr_q, waddr_d, raddr_q, raddr_d;
   logic [1:0]        alu_q, alu_d;
   logic [DATA_W-1:0] imm_q, imm_d;

   assign op = ir[INS_W-1 -: 3];
   assign rd = ir[RA_W-1:0];

`ifdef CTRL_STEP_EN
   assign go = step;
`else
   assign go = 1'b1;
`endif

   pc_reg #(.PC_W(PC_W)) u_pc (
      .clk    (clk),
      .clr    (start),
      .inc    (pc_inc),
      .ld     (pc_ld),
      .ld_val (opnd[PC_W-1:0]),
      .pc     (pc)
   );

   // State, instruction/operand latches and held control-output values.
   always_ff @(posedge clk) begin
      if (start) begin
         state   <= FETCH;
         ir      <= '0;
         opnd    <= '0;
         waddr_q <= '0;
         raddr_q <= '0;
         alu_q   <= ALU_PASS_IMM;
         imm_q   <= '0;
      end else begin
         state   <= state_d;
         if (ir_en)   ir   <= ins;
         if (opnd_en) opnd <= ins;
         waddr_q <= waddr_d;
         raddr_q <= raddr_d;
         alu_q   <= alu_d;
         imm_q   <= imm_d;
      end
   end

   // Next state, PC control and execute-cycle control values.
   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_d = state;
      pc_inc  = 1'b0;
      pc_ld   = 1'b0;
      ir_en   = 1'b0;
      opnd_en = 1'b0;
      we_d    = 1'b0;
      halt_d  = (state == HALTED);
      waddr_d = waddr_q;
      raddr_d = raddr_q;
      alu_d   = alu_q;
      imm_d   = imm_q;
      case (state)
         FETCH: begin
            if (go) begin
               pc_inc  = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            ir_en = 1'b1;
            if (is_two_word(ins[INS_W-1 -: 3])) begin
               pc_inc  = 1'b1;
               state_d = OPND;
            end else begin
               state_d = EXEC;
            end
         end
         OPND: begin
            opnd_en = 1'b1;
            state_d = EXEC;
         end
         EXEC: begin
            state_d = FETCH;
            case (op)
               OP_LDI: begin
                  we_d    = 1'b1;
                  waddr_d = rd;
                  alu_d   = ALU_PASS_IMM;
                  imm_d   = DATA_W'(opnd);
               end
               OP_ADD, OP_SUB: begin
                  we_d    = 1'b1;
                  waddr_d = rd;
                  raddr_d = rd;
                  alu_d   = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
               end
               OP_MOV: begin
                  we_d    = 1'b1;
                  waddr_d = '0;
                  raddr_d = rd;
                  alu_d   = ALU_PASS_REG;
               end
               OP_JMP:  pc_ld = 1'b1;
               OP_JZ:   pc_ld = zero;
               OP_HALT: begin
                  halt_d  = 1'b1;
                  state_d = HALTED;
               end
               default: ;
            endcase
         end
         HALTED:  ;
         default: state_d = FETCH;
      endcase
   end

   // A strobe never escapes in a cycle where reset is being applied.
   assign rf_we    = we_d & ~start;
   assign r_addr   = pc;
   assign w_addr   = PC_W'(SCRATCH_ADDR);
   assign rf_waddr = waddr_d;
   assign rf_raddr = raddr_d;
   assign alu_op   = alu_d;
   assign imm      = imm_d;
   assign halted   = halt_d;

endmodule
